cmp_serial_nbit: RTL and testbench

CMP_SERIAL_NBIT -- requirements
Module: cmp_serial_nbit

---
 rtl/cmp_serial_nbit.sv | 111 +++++++++++
 tb/tb_cmp_serial_nbit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_serial_nbit.sv
// Bit-serial (SLICE bits/cycle) comparator: EQ, NE, LTU, LTS.
// Define CMP_SIGNED_EN to enable the signed compare for op=3 (otherwise it aliases LTU).
module cmp_serial_nbit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Y
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_eq;
  logic             r_lt;
  logic             r_y;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;

  logic [SLICE-1:0] w_ak;
  logic [SLICE-1:0] w_bk;
  logic             w_last;
  logic             w_eq_nx;
  logic             w_lt_nx;
  logic             w_lts;
  logic             w_res;

  assign w_ak    = r_a[r_cnt*SLICE +: SLICE];
  assign w_bk    = r_b[r_cnt*SLICE +: SLICE];
  assign w_last  = (r_cnt == CW'(NSLICE - 1));
  assign w_eq_nx = r_eq & (w_ak == w_bk);
  // Higher slices override the verdict of lower ones unless they tie.
  assign w_lt_nx = (w_ak < w_bk) | ((w_ak == w_bk) & r_lt);

`ifdef CMP_SIGNED_EN
  assign w_lts = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? r_a[WIDTH-1] : w_lt_nx;
`else
  assign w_lts = w_lt_nx;
`endif

  always_comb begin
    w_res = 1'b0;
    case (r_op)
      2'd0:    w_res = w_eq_nx;
      2'd1:    w_res = ~w_eq_nx;
      2'd2:    w_res = w_lt_nx;
      default: w_res = w_lts;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_eq    <= 1'b1;
      r_lt    <= 1'b0;
      r_y     <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= op;
            r_cnt   <= '0;
            r_eq    <= 1'b1;
            r_lt    <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_eq <= w_eq_nx;
          r_lt <= w_lt_nx;
          if (w_last) begin
            r_y     <= w_res;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign Y         = r_y;

endmodule

// File: tb/tb_cmp_serial_nbit.sv
// Scoreboard bench for cmp_serial_nbit (WIDTH=32, SLICE=4).
// Expected results come from plain integer comparison of the operands.
module tb_cmp_serial_nbit;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [1:0]  op = '0;
  logic        in_ready;
  logic        out_valid;
  logic        Y;

  cmp_serial_nbit #(.WIDTH(32), .SLICE(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic y;
    int   acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   seen = 0;
  int   last_acc = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic model(logic [31:0] a, logic [31:0] b,
                                 logic [1:0] o);
    case (o)
      2'd0: return a == b;
      2'd1: return a != b;
      2'd2: return a < b;
      default: begin
`ifdef CMP_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
      end
    endcase
  endfunction

  task automatic send(logic [31:0] a, logic [31:0] b,
                      logic [1:0] o, bit keep);
    int t = 0;
    @(negedge clk);
    A = a;
    B = b;
    op = o;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    q.push_back('{model(a, b, o), cyc + 1});
    last_acc = cyc + 1;
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    op = 2'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        if (!seen) begin
          chk("latency", cyc - q[0].acc, N);
          seen = 1;
        end
        chk("Y", Y, q[0].y);
        chk("in_ready_in_done", in_ready, 0);
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, msk;
    logic [1:0]  o;
    int          prev, t, sel;

    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_Y", Y, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    send(32'hDEADBEEF, 32'hDEADBEEF, 2'd0, 0);
    send(32'hDEADBEEF, 32'hDEADBEEE, 2'd0, 0);
    send(32'h80000000, 32'h00000000, 2'd1, 0);
    send(32'h12345678, 32'h12345678, 2'd1, 0);
    send(32'h7FFFFFFF, 32'h80000000, 2'd2, 0);
    send(32'h7FFFFFFF, 32'h80000000, 2'd3, 0);
    send(32'hFFFFFFFF, 32'h00000001, 2'd3, 0);
    drain();

    // Consumer stall: hold DONE for 5 cycles while junk requests arrive.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h00000001, 32'h00000002, 2'd2, 0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_reach_done", out_valid, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      A = $urandom;
      B = $urandom;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    drain();

    // Asynchronous abort while slice 3 is being processed.
    send(32'h7FFFFFFF, 32'h80000000, 2'd2, 0);
    drain();
    send(32'h00000010, 32'h00000020, 2'd2, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_Y", Y, 0);
    void'(q.pop_back());
    seen = 0;
    #1 rst = 1'b0;
    send(32'd3, 32'd5, 2'd2, 0);
    drain();

    // Back-to-back with in_valid held high.
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      send($urandom, $urandom, 2'd2, 1);
      if (i > 0) chk("b2b_period", last_acc - prev, N + 2);
      prev = last_acc;
    end
    in_valid = 1'b0;
    drain();

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      sel = $urandom_range(0, 2);
      msk = 32'hF;
      msk = msk << (4 * $urandom_range(0, 7));
      if (sel == 0) b = a;
      else if (sel == 1) b = a ^ (msk & $urandom);
      else b = $urandom;
      o = 2'($urandom);
      send(a, b, o, 0);
    end
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
